// File: rtl/wi23_defs.sv
// Shared memory-map constants and state types for the wi23 SoC peripherals.
// Holds the UART window base, its register offsets, STATUS bit positions and FSM enums.
package wi23_defs;

  localparam logic [15:0] ADDR_UART_MMAP = 16'hC010;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_RXDATA = 4'h4;
  localparam logic [3:0] UART_STATUS = 4'h8;
  localparam logic [3:0] UART_BAUD   = 4'hC;

  localparam int unsigned ST_TX_BUSY   = 0;
  localparam int unsigned ST_RX_NEMPTY = 1;
  localparam int unsigned ST_RX_OVR    = 2;
  localparam int unsigned ST_RX_FERR   = 3;
  localparam int unsigned ST_TX_OVR    = 4;
  localparam int unsigned ST_RX_COUNT  = 8;

  localparam logic [15:0] UART_MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Small divisors would leave no room for the half-bit start check.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < UART_MIN_DIV) ? UART_MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling FSM and deserializer.
// Emits a one-cycle rx_valid with rx_byte on a good stop bit, or an rx_ferr pulse on a bad one.
module uart_rx
  import wi23_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [15:0] div,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_ferr
);

  logic        sync1_q, sync2_q, prev_q;
  rx_state_e   state_q;
  logic [15:0] div_q, cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        valid_q, ferr_q;
  logic        fall;

  assign fall = prev_q & ~sync2_q;

  // Idle-high reset keeps a spurious falling edge from appearing after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RxIdle;
      div_q   <= 16'd0;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RxIdle: begin
          if (fall) begin
            state_q <= RxStart;
            div_q   <= div;
            cnt_q   <= (div >> 1) - 16'd1;
          end
        end
        RxStart: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (sync2_q) begin
            state_q <= RxIdle;
          end else begin
            state_q <= RxData;
            cnt_q   <= div_q - 16'd1;
            idx_q   <= 3'd0;
          end
        end
        RxData: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q <= {sync2_q, shift_q[7:1]};
            cnt_q   <= div_q - 16'd1;
            if (idx_q == 3'd7) state_q <= RxStop;
            else               idx_q   <= idx_q + 3'd1;
          end
        end
        RxStop: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q <= RxIdle;
            if (sync2_q) valid_q <= 1'b1;
            else         ferr_q  <= 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign rx_valid = valid_q;
  assign rx_byte  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/mmap_uart.sv
// Memory-mapped 8N1 UART: TX holding/shift FSM, RX FIFO with sticky flags, register file
// and combinational read mux.
module mmap_uart
  import wi23_defs::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_i,
  input  logic [3:0]  addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        RX,
  output logic        TX
);

  localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH) + 1;
  localparam int unsigned IdxW = PtrW - 1;
  localparam logic [15:0] DivReset = 16'(CLK_FREQ / BAUD);

  logic [1:0] reg_sel;
  logic       wr_en, rd_en, wr_tx, wr_status, wr_baud, rd_rx;
  logic       unused_bits;

  assign reg_sel   = addr_i[3:2];
  assign wr_en     = sel_i & we_i;
  assign rd_en     = sel_i & re_i;
  assign wr_tx     = wr_en & (reg_sel == UART_TXDATA[3:2]);
  assign wr_status = wr_en & (reg_sel == UART_STATUS[3:2]);
  assign wr_baud   = wr_en & (reg_sel == UART_BAUD[3:2]);
  assign rd_rx     = rd_en & (reg_sel == UART_RXDATA[3:2]);
  assign unused_bits = ^{wdata_i[31:16], addr_i[1:0]};

  logic [15:0] baud_div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       baud_div_q <= DivReset;
    else if (wr_baud) baud_div_q <= clamp_div(wdata_i[15:0]);
  end

  // ---------------- transmitter ----------------
  tx_state_e   tx_state_q;
  logic        tx_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_shift_q;
  logic        tx_busy, tx_finishing, tx_accept, tx_ovr_set;

  assign tx_busy      = (tx_state_q != TxIdle);
  assign tx_finishing = (tx_state_q == TxStop) && (tx_cnt_q == 16'd0);
  // A write landing on the stop-bit's last edge starts the next frame back to back.
  assign tx_accept    = wr_tx & (~tx_busy | tx_finishing);
  assign tx_ovr_set   = wr_tx & ~tx_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_q       <= 1'b1;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= DivReset;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'd0;
    end else if (tx_accept) begin
      tx_state_q <= TxStart;
      tx_q       <= 1'b0;
      tx_div_q   <= baud_div_q;
      tx_cnt_q   <= baud_div_q - 16'd1;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= wdata_i[7:0];
    end else if (tx_busy) begin
      if (tx_cnt_q != 16'd0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= tx_div_q - 16'd1;
        case (tx_state_q)
          TxStart: begin
            tx_state_q <= TxData;
            tx_q       <= tx_shift_q[0];
          end
          TxData: begin
            if (tx_idx_q == 3'd7) begin
              tx_state_q <= TxStop;
              tx_q       <= 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end
          TxStop:  tx_state_q <= TxIdle;
          default: tx_state_q <= TxIdle;
        endcase
      end
    end
  end

  assign TX = tx_q;

  // ---------------- receiver and FIFO ----------------
  logic       rx_valid, rx_ferr_pulse;
  logic [7:0] rx_byte;

  uart_rx u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (RX),
    .div      (baud_div_q),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr_pulse)
  );

  logic [7:0]      fifo_mem [RX_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, count;
  logic            empty, full, pop, push_ok, rx_ovr_set;
  logic [2:0]      rx_count;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  assign full     = (count == PtrW'(RX_FIFO_DEPTH));
  assign pop      = rd_rx & ~empty;
  // Pop frees the slot first, so a push into a full FIFO survives a same-cycle pop.
  assign push_ok    = rx_valid & (~full | pop);
  assign rx_ovr_set = rx_valid & full & ~pop;
  assign rx_count   = 3'(count);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[IdxW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------- sticky flags ----------------
  logic       rx_ovr_q, rx_ferr_q, tx_ovr_q;
  logic [4:2] clr;

  assign clr = wr_status ? wdata_i[4:2] : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      tx_ovr_q  <= 1'b0;
    end else begin
      rx_ovr_q  <= rx_ovr_set    | (rx_ovr_q  & ~clr[ST_RX_OVR]);
      rx_ferr_q <= rx_ferr_pulse | (rx_ferr_q & ~clr[ST_RX_FERR]);
      tx_ovr_q  <= tx_ovr_set    | (tx_ovr_q  & ~clr[ST_TX_OVR]);
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] status;

  always_comb begin
    status                     = 32'd0;
    status[ST_TX_BUSY]         = tx_busy;
    status[ST_RX_NEMPTY]       = ~empty;
    status[ST_RX_OVR]          = rx_ovr_q;
    status[ST_RX_FERR]         = rx_ferr_q;
    status[ST_TX_OVR]          = tx_ovr_q;
    status[ST_RX_COUNT +: 3]   = rx_count;
  end

  always_comb begin
    rdata_o = 32'd0;
    case (reg_sel)
      UART_RXDATA[3:2]: if (!empty) rdata_o[7:0] = fifo_mem[rd_ptr_q[IdxW-1:0]];
      UART_STATUS[3:2]: rdata_o = status;
      UART_BAUD[3:2]:   rdata_o[15:0] = baud_div_q;
      default:          rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mmap_uart.sv
// Scoreboard bench for mmap_uart: bus reads and TX frames are checked by independent monitors
// against a queue/time based model of the register map, FIFO and serial line.
module tb_mmap_uart;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_i = 1'b0, we_i = 1'b0, re_i = 1'b0;
  logic [3:0]  addr_i = 4'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        rx_line = 1'b1;
  logic        tx_line;

  always #10 clk = ~clk;

  mmap_uart dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_i   (sel_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .re_i    (re_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .RX      (rx_line),
    .TX      (tx_line)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  int          div_m = 434;
  logic [7:0]  fifo_m[$];
  bit          rx_ovr_m = 0, rx_ferr_m = 0, tx_ovr_m = 0;
  int          tx_end = 0;
  bit          mon_off = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_byte_q[$];
  int          tx_div_q[$];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    int sz;
    sz = fifo_m.size();
    s = 32'h0;
    s[0] = (cyc < tx_end);
    s[1] = (sz != 0);
    s[2] = rx_ovr_m;
    s[3] = rx_ferr_m;
    s[4] = tx_ovr_m;
    s[10:8] = sz[2:0];
    return s;
  endfunction

  // All bus tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(posedge clk); #1;
    sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string n);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(n);
    sel_i = 1'b1; re_i = 1'b1; addr_i = a;
    @(posedge clk); #1;
    sel_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic read_status(input string n);
    bus_read(4'h8, status_exp(), n);
  endtask

  task automatic read_rx(input string n);
    logic [31:0] e;
    e = 32'h0;
    if (fifo_m.size() != 0) begin
      e[7:0] = fifo_m[0];
      void'(fifo_m.pop_front());
    end
    bus_read(4'h4, e, n);
  endtask

  task automatic set_baud(input int v);
    bus_write(4'hC, 32'(v));
    div_m = (v < 4) ? 4 : v;
  endtask

  task automatic w1c(input logic [31:0] v);
    bus_write(4'h8, v);
    if (v[2]) rx_ovr_m = 0;
    if (v[3]) rx_ferr_m = 0;
    if (v[4]) tx_ovr_m = 0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_write(4'h0, {24'h0, b});
    if (cyc >= tx_end) begin
      tx_end = cyc + 10 * div_m;
      if (!mon_off) begin
        tx_byte_q.push_back(b);
        tx_div_q.push_back(div_m);
      end
    end else begin
      tx_ovr_m = 1;
    end
  endtask

  task automatic wait_tx_idle();
    while (cyc < tx_end) idle(1);
    idle(2);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = fr[i];
      repeat (div_m) @(posedge clk);
      #1;
    end
    rx_line = 1'b1;
    idle(2);
    if (!stop_ok)                 rx_ferr_m = 1;
    else if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
    else                          rx_ovr_m = 1;
  endtask

  // Read-data monitor
  initial forever begin
    @(negedge clk);
    if (sel_i && re_i) begin
      if (rd_exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string n;
        e = rd_exp_q.pop_front();
        n = rd_name_q.pop_front();
        check(n, rdata_o, e);
      end
    end
  end

  // Serial TX monitor: decodes frames at mid-bit using the divisor recorded at frame start.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !tx_line && !mon_off) begin
        if (tx_byte_q.size() == 0) begin
          check("tx_unexpected", 32'd1, 32'd0);
          prev = 1'b0;
        end else begin
          logic [7:0] eb, got;
          logic st, sp;
          int d;
          eb = tx_byte_q.pop_front();
          d  = tx_div_q.pop_front();
          repeat (d / 2) @(negedge clk);
          st = tx_line;
          for (int j = 0; j < 8; j++) begin
            repeat (d) @(negedge clk);
            got[j] = tx_line;
          end
          repeat (d) @(negedge clk);
          sp = tx_line;
          check("tx_byte", {24'h0, got}, {24'h0, eb});
          check("tx_start_stop", {30'h0, st, sp}, 32'h1);
          prev = tx_line;
        end
      end else begin
        prev = tx_line;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    read_status("reset_status");
    read_rx("reset_rxdata");
    bus_read(4'hC, 32'd434, "reset_baud");
    bus_read(4'h0, 32'd0, "txdata_reads_zero");
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_line !== 1'b1) lows++;
    end
    idle(1);
    check("tx_idle_high", 32'(lows), 32'd0);

    // Baud clamp
    set_baud(2);
    bus_read(4'hC, 32'(div_m), "baud_clamp");
    set_baud(8);
    bus_read(4'hC, 32'd8, "baud_set");

    // Exact A5 waveform with busy tracked by continuous STATUS reads
    tx_write(8'hA5);
    fork
      begin
        int mism;
        logic [7:0] pat;
        logic eb;
        pat = 8'hA5;
        mism = 0;
        for (int t = 0; t < 90; t++) begin
          @(negedge clk);
          if (t < 8)       eb = 1'b0;
          else if (t < 72) eb = pat[(t - 8) / 8];
          else             eb = 1'b1;
          if (tx_line !== eb) mism++;
        end
        check("tx_wave_a5", 32'(mism), 32'd0);
      end
      begin
        for (int i = 0; i < 90; i++) begin
          rd_exp_q.push_back(status_exp());
          rd_name_q.push_back("tx_busy_window");
          sel_i = 1'b1; re_i = 1'b1; addr_i = 4'h8;
          @(posedge clk); #1;
        end
        sel_i = 1'b0; re_i = 1'b0;
      end
    join
    wait_tx_idle();

    // TX overrun and W1C
    b = 8'($urandom);
    tx_write(b);
    idle(5);
    tx_write(8'h3C);
    read_status("tx_ovr_set");
    w1c(32'h10);
    read_status("tx_ovr_cleared");
    wait_tx_idle();

    // Random TX frames with a mid-frame divisor change
    for (int k = 0; k < 5; k++) begin
      set_baud(int'($urandom_range(4, 12)));
      tx_write(8'($urandom));
      idle(int'($urandom_range(1, 3 * div_m)));
      set_baud(int'($urandom_range(4, 12)));
      wait_tx_idle();
    end
    read_status("after_random_tx");

    // RX overflow
    set_baud(8);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    send_rx(8'h55, 1'b1);
    read_status("rx_full_ovr");
    for (int i = 0; i < 5; i++) read_rx("rx_drain");
    read_status("rx_drained");
    w1c(32'h04);
    read_status("rx_ovr_cleared");

    // Glitch and framing error
    rx_line = 1'b0;
    idle(3);
    rx_line = 1'b1;
    idle(30);
    read_status("rx_glitch");
    send_rx(8'h77, 1'b1);
    send_rx(8'h5A, 1'b0);
    read_status("rx_ferr");
    w1c(32'h08);
    read_rx("rx_after_ferr");
    read_status("rx_ferr_cleared");

    // Random RX frames
    for (int k = 0; k < 6; k++) begin
      set_baud(int'($urandom_range(8, 20)));
      send_rx(8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) read_rx("rx_random");
      read_status("rx_random_status");
    end
    for (int i = 0; i < 5; i++) read_rx("rx_random_drain");
    w1c(32'h1C);

    // Pop on the same edge as a push into a full FIFO
    set_baud(8);
    for (int i = 0; i < 4; i++) send_rx(8'($urandom), 1'b1);
    b = 8'($urandom);
    begin
      int s, p;
      s = cyc;
      p = s + 4 + div_m / 2 + 9 * div_m;
      fork
        send_rx(b, 1'b1);
        begin
          while (cyc < p - 1) idle(1);
          read_rx("pop_on_push_head");
        end
      join
    end
    read_status("pop_on_push_status");
    for (int i = 0; i < 5; i++) read_rx("pop_on_push_drain");

    // Asynchronous reset mid-frame
    wait_tx_idle();
    mon_off = 1;
    tx_write(8'h00);
    idle(20);
    #3 rst_n = 1'b0;
    #1 check("tx_async_reset", {31'h0, tx_line}, 32'd1);
    idle(3);
    rst_n = 1'b1;
    fifo_m.delete();
    rx_ovr_m = 0; rx_ferr_m = 0; tx_ovr_m = 0;
    div_m = 434;
    tx_end = 0;
    idle(2);
    read_status("post_reset_status");
    bus_read(4'hC, 32'd434, "post_reset_baud");
    idle(2);

    check("tx_frames_pending", 32'(tx_byte_q.size()), 32'd0);
    check("rd_pending", 32'(rd_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
